// File: rtl/cnt_load_arbiter.sv
// Round-robin arbiter sharing one loadable-counter write port between NREQ requesters.
// Latency: grant edge -> wr/ack for one cycle -> old_cnt/old_valid one cycle later.
// Backpressure: requesters hold req until ack; no new grant while busy (WRITE + GAP) or en=0.
module cnt_load_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int GAP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               wr,
  output logic [DW-1:0]      wdata,
  output logic [2:0]         grant_id,
  input  logic [DW-1:0]      data_cnt,
  output logic [DW-1:0]      old_cnt,
  output logic               old_valid,
  output logic               busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] GAP_ST = 2'd2;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // gap_cnt counts GAP-1 down to 0, so it only needs to hold GAP-1
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]    state;
  logic [2:0]    last;
  logic [GW-1:0] gap_cnt;
  logic          win_vld;
  logic [2:0]    win_idx;

  // Circular search starting just after the last winner; modulo keeps indices below NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && req[IW'((int'(last) + k) % NREQ)]) begin
        win_vld = 1'b1;
        win_idx = 3'((int'(last) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 3'(NREQ - 1);
      gap_cnt   <= '0;
      ack       <= '0;
      wr        <= 1'b0;
      wdata     <= '0;
      grant_id  <= '0;
      old_cnt   <= '0;
      old_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      old_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en && win_vld) begin
            wr       <= 1'b1;
            wdata    <= req_data[int'(win_idx)*DW +: DW];
            ack      <= NREQ'(1) << win_idx;
            grant_id <= win_idx;
            last     <= win_idx;
            busy     <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // Counter loads on this same edge, so data_cnt is still the pre-load value.
          old_cnt   <= data_cnt;
          old_valid <= 1'b1;
          wr        <= 1'b0;
          ack       <= '0;
          if (GAP > 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP_ST;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GAP_ST: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          wr    <= 1'b0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_load_arbiter.sv
// Bench for cnt_load_arbiter: a GAP=2/NREQ=4 instance and a GAP=0/NREQ=3 instance,
// each driving its own loadable counter, checked against a grant-timing model.
module tb_cnt_load_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        en_a, wr_a, ov_a, busy_a;
  logic [3:0]  req_a, ack_a;
  logic [31:0] rd_a;
  logic [7:0]  wdata_a, cnt_a, oc_a;
  logic [2:0]  gid_a;

  logic        en_b, wr_b, ov_b, busy_b;
  logic [2:0]  req_b, ack_b;
  logic [23:0] rd_b;
  logic [7:0]  wdata_b, cnt_b, oc_b;
  logic [2:0]  gid_b;

  cnt_load_arbiter #(.NREQ(4), .DW(8), .GAP(2)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .req(req_a), .req_data(rd_a),
    .ack(ack_a), .wr(wr_a), .wdata(wdata_a), .grant_id(gid_a),
    .data_cnt(cnt_a), .old_cnt(oc_a), .old_valid(ov_a), .busy(busy_a));

  cnt_load_arbiter #(.NREQ(3), .DW(8), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .req(req_b), .req_data(rd_b),
    .ack(ack_b), .wr(wr_b), .wdata(wdata_b), .grant_id(gid_b),
    .data_cnt(cnt_b), .old_cnt(oc_b), .old_valid(ov_b), .busy(busy_b));

  // Free-running loadable counters fed by the arbiters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      cnt_a <= wr_a ? wdata_a : cnt_a + 8'd1;
      cnt_b <= wr_b ? wdata_b : cnt_b + 8'd1;
    end
  end

  // Reference model: a grant is legal at edge t once t reaches the earliest free edge
  longint      t;
  longint      m_free[2];
  int          m_last[2];
  bit          m_wr[2];
  logic [7:0]  m_wdata[2];
  logic [7:0]  m_ack[2];
  int          m_gid[2];
  bit          m_ov[2];
  logic [7:0]  m_oc[2];
  bit          m_busy[2];
  logic [7:0]  m_cnt[2];

  int n_cmp = 0;
  int n_bad = 0;

  int         g_n;
  int         g_id[16];
  longint     g_t[16];
  logic [7:0] g_wd[16];

  function automatic int nr(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int gp(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int d = 0; d < 2; d++) begin
      m_free[d]  = 0;
      m_last[d]  = nr(d) - 1;
      m_wr[d]    = 1'b0;
      m_wdata[d] = '0;
      m_ack[d]   = '0;
      m_gid[d]   = 0;
      m_ov[d]    = 1'b0;
      m_oc[d]    = '0;
      m_busy[d]  = 1'b0;
      m_cnt[d]   = '0;
    end
  endtask

  task automatic model_edge();
    t++;
    for (int d = 0; d < 2; d++) begin
      logic [7:0]  rq;
      logic [63:0] rd;
      logic        e;
      int          w;
      rq = (d == 0) ? {4'b0, req_a} : {5'b0, req_b};
      rd = (d == 0) ? {32'b0, rd_a} : {40'b0, rd_b};
      e  = (d == 0) ? en_a : en_b;
      m_ov[d] = m_wr[d];
      if (m_wr[d]) m_oc[d] = m_cnt[d];
      m_cnt[d] = m_wr[d] ? m_wdata[d] : m_cnt[d] + 8'd1;
      m_wr[d]  = 1'b0;
      m_ack[d] = '0;
      if (t >= m_free[d] && e && rq != 0) begin
        w = -1;
        for (int k = 1; k <= nr(d) && w < 0; k++)
          if (rq[(m_last[d] + k) % nr(d)]) w = (m_last[d] + k) % nr(d);
        m_wr[d]    = 1'b1;
        m_ack[d]   = 8'd1 << w;
        m_wdata[d] = rd[w*8 +: 8];
        m_gid[d]   = w;
        m_last[d]  = w;
        m_free[d]  = t + 2 + gp(d);
      end
      m_busy[d] = (t < m_free[d] - 1);
    end
  endtask

  task automatic check_all();
    chk("a.wr", wr_a, m_wr[0]);
    chk("a.ack", ack_a, m_ack[0]);
    chk("a.wdata", wdata_a, m_wdata[0]);
    chk("a.grant_id", gid_a, m_gid[0]);
    chk("a.old_valid", ov_a, m_ov[0]);
    chk("a.old_cnt", oc_a, m_oc[0]);
    chk("a.busy", busy_a, m_busy[0]);
    chk("a.counter", cnt_a, m_cnt[0]);
    chk("b.wr", wr_b, m_wr[1]);
    chk("b.ack", ack_b, m_ack[1]);
    chk("b.wdata", wdata_b, m_wdata[1]);
    chk("b.grant_id", gid_b, m_gid[1]);
    chk("b.old_valid", ov_b, m_ov[1]);
    chk("b.old_cnt", oc_b, m_oc[1]);
    chk("b.busy", busy_b, m_busy[1]);
    chk("b.counter", cnt_b, m_cnt[1]);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_grants_a(input int n, input int budget, input bit drop);
    g_n = 0;
    for (int c = 0; c < budget && g_n < n; c++) begin
      cycle();
      if (wr_a) begin
        g_id[g_n] = int'(gid_a);
        g_t[g_n]  = t;
        g_wd[g_n] = wdata_a;
        g_n++;
      end
      if (drop) req_a = req_a & ~ack_a;
    end
    chk("a.grant_budget", g_n, n);
  endtask

  initial begin
    reset = 1'b0;
    en_a = 1'b0; req_a = '0; rd_a = '0;
    en_b = 1'b0; req_b = '0; rd_b = '0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.wr", wr_a, 0);
    chk("rst.ack", ack_a, 0);
    chk("rst.wdata", wdata_a, 0);
    chk("rst.grant_id", gid_a, 0);
    chk("rst.old_cnt", oc_a, 0);
    chk("rst.old_valid", ov_a, 0);
    chk("rst.busy", busy_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Single grant to requester 0
    en_a = 1'b1; req_a = 4'b0001; rd_a[7:0] = 8'h55;
    cycle();
    chk("t1.wr", wr_a, 1);
    chk("t1.ack", ack_a, 4'b0001);
    chk("t1.wdata", wdata_a, 8'h55);
    req_a = '0;
    cycle();
    chk("t1.wr_low", wr_a, 0);
    chk("t1.old_valid", ov_a, 1);
    chk("t1.old_cnt", oc_a, 8'h01);
    chk("t1.counter", cnt_a, 8'h55);
    cycle();
    chk("t1.old_valid_pulse", ov_a, 0);

    // All four requesting: rotation and spacing
    do_reset();
    rd_a = {8'h40, 8'h30, 8'h20, 8'h10};
    req_a = 4'b1111;
    run_grants_a(5, 40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2.grant_seq", g_id[i], i % 4);
      chk("t2.wdata", g_wd[i], 8'h10 * ((i % 4) + 1));
    end
    for (int i = 1; i < 5; i++) chk("t2.spacing", 32'(g_t[i] - g_t[i-1]), 4);

    // After requester 2 wins, 0101 favours 0 then 2
    do_reset();
    req_a = 4'b0100;
    run_grants_a(1, 10, 1'b1);
    chk("t3.first", g_id[0], 2);
    req_a = 4'b0101;
    run_grants_a(2, 20, 1'b1);
    chk("t3.grant0", g_id[0], 0);
    chk("t3.grant1", g_id[1], 2);

    // en low blocks grants
    en_a = 1'b0; req_a = '0;
    repeat (5) cycle();
    req_a = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t4.no_wr", wr_a, 0);
      chk("t4.no_ack", ack_a, 0);
      chk("t4.idle", busy_a, 0);
    end
    en_a = 1'b1;
    cycle();
    chk("t4.grant_wr", wr_a, 1);
    chk("t4.grant_ack", ack_a, 4'b0010);
    req_a = '0;

    // Reset during the write cycle
    req_a = 4'b1000; rd_a[31:24] = 8'hA5;
    for (int i = 0; i < 20 && !wr_a; i++) begin
      cycle();
    end
    chk("t5.wr_seen", wr_a, 1);
    reset = 1'b1;
    #1;
    chk("t5.wr_drop", wr_a, 0);
    chk("t5.ack_drop", ack_a, 0);
    chk("t5.busy_drop", busy_a, 0);
    chk("t5.ov_drop", ov_a, 0);
    model_reset();
    #1;
    reset = 1'b0;
    req_a = 4'b1111;
    run_grants_a(1, 10, 1'b1);
    chk("t5.prio0", g_id[0], 0);

    // GAP=0 instance alternates every 2 cycles
    en_a = 1'b0; req_a = '0;
    en_b = 1'b1; req_b = 3'b011; rd_b = {8'h00, 8'hB1, 8'hB0};
    g_n = 0;
    for (int c = 0; c < 20 && g_n < 4; c++) begin
      cycle();
      if (wr_b) begin
        g_id[g_n] = int'(gid_b);
        g_t[g_n]  = t;
        g_n++;
      end
    end
    chk("t6.grant_budget", g_n, 4);
    for (int i = 0; i < 4; i++) chk("t6.grant_seq", g_id[i], i % 2);
    for (int i = 1; i < 4; i++) chk("t6.spacing", 32'(g_t[i] - g_t[i-1]), 2);
    req_b = '0;

    // Random traffic on both instances
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_a[i] && $urandom_range(0, 3) == 0) begin
          rd_a[i*8 +: 8] = 8'($urandom);
          req_a[i] = 1'b1;
        end
      for (int i = 0; i < 3; i++)
        if (!req_b[i] && $urandom_range(0, 3) == 0) begin
          rd_b[i*8 +: 8] = 8'($urandom);
          req_b[i] = 1'b1;
        end
      en_a = ($urandom_range(0, 7) != 0);
      en_b = ($urandom_range(0, 7) != 0);
      cycle();
      chk("b.gid_range", {31'b0, gid_b <= 3'd2}, 1);
      req_a = req_a & ~ack_a;
      req_b = req_b & ~ack_b;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
